// File: rtl/calc_pkg.sv
// Purpose: shared types and constants for the calculator sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc_pkg;

    // The encoding is visible on state_o, so each value is fixed explicitly.
    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_SHOW    = 2'd3
    } calc_state_t;

    // Display-source select codes.
    localparam logic [1:0] DISP_SW  = 2'd0;
    localparam logic [1:0] DISP_A   = 2'd1;
    localparam logic [1:0] DISP_B   = 2'd2;
    localparam logic [1:0] DISP_RES = 2'd3;

    // Operation codes.
    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/btn_conditioner.sv
// Purpose: 2-FF synchroniser, debounce counter and rising-edge pulse for one raw button.
// Latency: pulse appears 2 + DEBOUNCE_CYCLES clocks after a clean press.
// Backpressure: none; the pulse is one cycle wide and is not held.
// Ports: clk, rst_n (async active-low), i_btn (raw level), o_pulse (1-cycle press pulse).
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000    // minimum 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int               CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_pulse;

    // The counter only advances while the synchronised sample differs from
    // the accepted level; any sample equal to the level restarts it, so a
    // change needs DEBOUNCE_CYCLES consecutive agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_pulse <= r_sync[1];    // only the 0->1 acceptance pulses
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/calc_sequencer.sv
// Purpose: sequences one calculation (enter A, enter B, compute, show) around an external ALU.
// Latency: confirm pulse in ENTER_B at cycle N -> COMPUTE at N+1 -> result_valid from N+2.
// Backpressure: none; button pulses that the current state does not use are dropped.
// Ports: clk, rst_n (async active-low); sw, op_sel, btn_confirm/clear/mode (raw inputs);
//        alu_result/alu_flag (from ALU); operand_a/b, op_latched (to ALU);
//        result, result_flag, result_valid, disp_sel, hex_mode, state_o (to display).
// Build option: define CALC_CHAIN_EN so a confirm in SHOW loads the result into operand A
//        and continues at ENTER_B, allowing chained operations.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             op_sel,
    input  logic             btn_confirm,
    input  logic             btn_clear,
    input  logic             btn_mode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_flag,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             op_latched,
    output logic [WIDTH-1:0] result,
    output logic             result_flag,
    output logic             result_valid,
    output logic [1:0]       disp_sel,
    output logic             hex_mode,
    output logic [1:0]       state_o
);

    logic w_confirm;
    logic w_clear;
    logic w_mode;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_confirm (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_confirm),
        .o_pulse(w_confirm)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_clear (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_clear),
        .o_pulse(w_clear)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_mode (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_mode),
        .o_pulse(w_mode)
    );

    calc_state_t      r_state;
    calc_state_t      w_state_next;
    logic             w_load_a;
    logic             w_load_b;
    logic             w_capture;
`ifdef CALC_CHAIN_EN
    logic             w_chain_a;
`endif

    logic [WIDTH-1:0] r_operand_a;
    logic [WIDTH-1:0] r_operand_b;
    logic             r_op_latched;
    logic [WIDTH-1:0] r_result;
    logic             r_result_flag;
    logic             r_result_valid;
    logic [1:0]       r_disp_sel;
    logic             r_hex_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ENTER_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear overrides everything, including a same-cycle confirm and the
    // COMPUTE capture; confirm is ignored in COMPUTE.
    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_capture    = 1'b0;
`ifdef CALC_CHAIN_EN
        w_chain_a    = 1'b0;
`endif
        case (r_state)
            ST_ENTER_A: begin
                if (w_confirm) begin
                    w_load_a     = 1'b1;
                    w_state_next = ST_ENTER_B;
                end
            end
            ST_ENTER_B: begin
                if (w_confirm) begin
                    w_load_b     = 1'b1;
                    w_state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                w_capture    = 1'b1;
                w_state_next = ST_SHOW;
            end
            ST_SHOW: begin
                if (w_confirm) begin
`ifdef CALC_CHAIN_EN
                    w_chain_a    = 1'b1;
                    w_state_next = ST_ENTER_B;
`else
                    w_state_next = ST_ENTER_A;
`endif
                end
            end
            default: w_state_next = ST_ENTER_A;
        endcase
        if (w_clear) begin
            w_state_next = ST_ENTER_A;
            w_load_a     = 1'b0;
            w_load_b     = 1'b0;
            w_capture    = 1'b0;
`ifdef CALC_CHAIN_EN
            w_chain_a    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_operand_a   <= '0;
            r_operand_b   <= '0;
            r_op_latched  <= OP_ADD;
            r_result      <= '0;
            r_result_flag <= 1'b0;
        end else if (w_clear) begin
            r_operand_a   <= '0;
            r_operand_b   <= '0;
            r_result      <= '0;
            r_result_flag <= 1'b0;
        end else begin
            if (w_load_a) begin
                r_operand_a <= sw;
            end
`ifdef CALC_CHAIN_EN
            if (w_chain_a) begin
                r_operand_a <= r_result;
            end
`endif
            if (w_load_b) begin
                r_operand_b  <= sw;
                r_op_latched <= op_sel;
            end
            if (w_capture) begin
                r_result      <= alu_result;
                r_result_flag <= alu_flag;
            end
        end
    end

    // Display-side outputs are registered from the next state so they line
    // up with r_state; COMPUTE keeps whatever select was already shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_valid <= 1'b0;
            r_disp_sel     <= DISP_SW;
            r_hex_mode     <= 1'b1;
        end else begin
            r_result_valid <= (w_state_next == ST_SHOW);
            case (w_state_next)
                ST_SHOW:    r_disp_sel <= DISP_RES;
                ST_COMPUTE: r_disp_sel <= r_disp_sel;
                default:    r_disp_sel <= DISP_SW;
            endcase
            if (w_mode) begin
                r_hex_mode <= ~r_hex_mode;
            end
        end
    end

    assign operand_a    = r_operand_a;
    assign operand_b    = r_operand_b;
    assign op_latched   = r_op_latched;
    assign result       = r_result;
    assign result_flag  = r_result_flag;
    assign result_valid = r_result_valid;
    assign disp_sel     = r_disp_sel;
    assign hex_mode     = r_hex_mode;
    assign state_o      = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       op_sel;
    logic       btn_confirm;
    logic       btn_clear;
    logic       btn_mode;
    logic [3:0] alu_result;
    logic       alu_flag;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic       op_latched;
    logic [3:0] result;
    logic       result_flag;
    logic       result_valid;
    logic [1:0] disp_sel;
    logic       hex_mode;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_sequencer #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .op_sel      (op_sel),
        .btn_confirm (btn_confirm),
        .btn_clear   (btn_clear),
        .btn_mode    (btn_mode),
        .alu_result  (alu_result),
        .alu_flag    (alu_flag),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op_latched  (op_latched),
        .result      (result),
        .result_flag (result_flag),
        .result_valid(result_valid),
        .disp_sel    (disp_sel),
        .hex_mode    (hex_mode),
        .state_o     (state_o)
    );

    // Behavioural model of the external arithmetic unit: bit 4 of the
    // 5-bit sum/difference is the carry on add and the borrow on subtract.
    logic [4:0] alu_wide;
    always_comb begin
        alu_wide = 5'd0;
        if (op_latched) alu_wide = {1'b0, operand_a} + {1'b0, operand_b};
        else            alu_wide = {1'b0, operand_a} - {1'b0, operand_b};
        alu_result = alu_wide[3:0];
        alu_flag   = alu_wide[4];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the chosen buttons long enough to be accepted and acted on,
    // then release and let the release debounce out.
    task automatic press(input logic c, input logic cl, input logic m);
        btn_confirm = c;
        btn_clear   = cl;
        btn_mode    = m;
        step(7);
        btn_confirm = 1'b0;
        btn_clear   = 1'b0;
        btn_mode    = 1'b0;
        step(8);
    endtask

    initial begin
        int rv_seen;
        int compute_seen;

        rst_n       = 1'b0;
        sw          = 4'd0;
        op_sel      = 1'b0;
        btn_confirm = 1'b0;
        btn_clear   = 1'b0;
        btn_mode    = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);

        // Reset state
        chk("rst_state", state_o, 0);
        chk("rst_result", result, 0);
        chk("rst_flag", result_flag, 0);
        chk("rst_hex", hex_mode, 1);
        chk("rst_disp", disp_sel, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_op", op_latched, 1);
        chk("rst_opa", operand_a, 0);

        // 5 + 3 with exact latency from the B confirm
        sw = 4'd5;
        press(1, 0, 0);
        chk("a_state", state_o, 1);
        chk("a_opa", operand_a, 5);
        chk("a_disp", disp_sel, 0);
        sw = 4'd3;
        op_sel = 1'b1;
        btn_confirm = 1'b1;
        step(6);                     // confirm pulse active now
        chk("b_pulse_state", state_o, 1);
        step(1);
        chk("b_compute_state", state_o, 2);
        chk("b_compute_valid", result_valid, 0);
        chk("b_compute_disp", disp_sel, 0);
        chk("b_opb", operand_b, 3);
        chk("b_op", op_latched, 1);
        step(1);
        chk("add_state", state_o, 3);
        chk("add_valid", result_valid, 1);
        chk("add_result", result, 8);
        chk("add_flag", result_flag, 0);
        chk("add_disp", disp_sel, 3);
        btn_confirm = 1'b0;
        step(8);
        chk("add_valid_hold", result_valid, 1);

`ifdef CALC_CHAIN_EN
        press(1, 0, 0);
        chk("chain_state", state_o, 1);
        chk("chain_opa", operand_a, 8);
        chk("chain_valid", result_valid, 0);
        sw = 4'd2;
        op_sel = 1'b0;
        press(1, 0, 0);
        chk("chain_result", result, 6);
        chk("chain_flag", result_flag, 0);
        chk("chain_end_state", state_o, 3);
`else
        press(1, 0, 0);
        chk("show_conf_state", state_o, 0);
        chk("show_conf_valid", result_valid, 0);
        chk("show_conf_opa", operand_a, 5);
        chk("show_conf_disp", disp_sel, 0);
`endif

        press(0, 1, 0);
        chk("clr_state", state_o, 0);
        chk("clr_opa", operand_a, 0);
        chk("clr_opb", operand_b, 0);
        chk("clr_result", result, 0);
        chk("clr_valid", result_valid, 0);

        // 3 - 5 wraps with borrow
        sw = 4'd3;
        press(1, 0, 0);
        sw = 4'd5;
        op_sel = 1'b0;
        press(1, 0, 0);
        chk("sub_state", state_o, 3);
        chk("sub_result", result, 4'hE);
        chk("sub_flag", result_flag, 1);
        chk("sub_op", op_latched, 0);
        press(0, 1, 0);
        chk("clr2_flag", result_flag, 0);

        // 9 + 9 carries out
        sw = 4'd9;
        press(1, 0, 0);
        op_sel = 1'b1;
        press(1, 0, 0);
        chk("carry_result", result, 2);
        chk("carry_flag", result_flag, 1);
        press(0, 1, 0);
        chk("clr3_state", state_o, 0);

        // Bouncing confirm gives exactly one advance
        sw = 4'd1;
        btn_confirm = 1'b1; step(1);
        btn_confirm = 1'b0; step(1);
        btn_confirm = 1'b1; step(12);
        btn_confirm = 1'b0; step(10);
        chk("bounce_state", state_o, 1);
        chk("bounce_opa", operand_a, 1);

        // Confirm accepted in ENTER_B, clear pulse lands in COMPUTE
        sw = 4'd2;
        op_sel = 1'b1;
        rv_seen = 0;
        compute_seen = 0;
        btn_confirm = 1'b1;
        step(1);
        btn_clear = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(1);
            if (result_valid) rv_seen++;
            if (state_o == 2'd2) compute_seen++;
        end
        btn_confirm = 1'b0;
        btn_clear = 1'b0;
        step(8);
        chk("cc_compute_seen", compute_seen, 1);
        chk("cc_valid_seen", rv_seen, 0);
        chk("cc_state", state_o, 0);
        chk("cc_result", result, 0);
        chk("cc_opb", operand_b, 0);

        // Same-cycle clear and confirm in ENTER_A: clear wins
        sw = 4'd7;
        press(1, 1, 0);
        chk("cc2_state", state_o, 0);
        chk("cc2_opa", operand_a, 0);

        // Mode toggling, alone and alongside clear / confirm
        press(0, 0, 1);
        chk("mode_hex0", hex_mode, 0);
        sw = 4'd4;
        press(1, 0, 0);
        chk("mode_pre_state", state_o, 1);
        press(0, 1, 1);
        chk("mode_clr_hex", hex_mode, 1);
        chk("mode_clr_state", state_o, 0);
        press(1, 0, 1);
        chk("mode_conf_hex", hex_mode, 0);
        chk("mode_conf_state", state_o, 1);
        chk("mode_conf_opa", operand_a, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
